// File: rtl/matmul_seq.sv
// Sequential signed fixed-point matrix multiplier, C = A x B.
// One shared multiply-accumulate per clock. rst high holds the block idle;
// releasing rst starts an operation (IDLE -> LOAD -> MAC -> DONE).
// ready is high only in IDLE. complete is high only in DONE.
// result, overflow and singular are held in DONE until rst is asserted.
module matmul_seq #(
  parameter int DATA_WIDTH  = 32,
  parameter int BIN_POS     = 16,
  parameter int MATRIX_SIZE = 3
) (
  input  logic                                            clk,
  input  logic                                            rst,
  output logic                                            ready,
  output logic                                            complete,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   mat_a,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   mat_b,
  input  logic                                            a_singular,
  output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   result,
  output logic                                            overflow,
  output logic                                            singular
);

  localparam int N  = MATRIX_SIZE;
  localparam int W  = DATA_WIDTH;
  localparam int MW = N * N * W;
  // The accumulator is wide enough to hold N full products without wrapping.
  localparam int AW = 2 * W + $clog2(N) + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_t;

  state_t               state_q, state_d;
  logic [MW-1:0]        a_q, b_q;
  logic [IW-1:0]        r_q, c_q, k_q;
  logic signed [AW-1:0] acc_q;

  logic                 last_mac;
  int                   a_idx, b_idx, c_idx;
  logic signed [W-1:0]  a_el, b_el;
  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0] sum, scaled;
  logic [AW-W:0]        hi;
  logic                 sat;
  logic [W-1:0]         elem;

  assign ready    = (state_q == IDLE);
  assign complete = (state_q == DONE);
  assign last_mac = (r_q == LAST) && (c_q == LAST) && (k_q == LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: singular operands skip straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = LOAD;
      LOAD:    state_d = a_singular ? DONE : MAC;
      MAC:     state_d = last_mac ? DONE : MAC;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // MAC datapath: product, accumulation, floor scaling and saturation.
  always_comb begin
    a_idx  = (int'(r_q) * N + int'(k_q)) * W;
    b_idx  = (int'(k_q) * N + int'(c_q)) * W;
    c_idx  = (int'(r_q) * N + int'(c_q)) * W;
    a_el   = a_q[a_idx +: W];
    b_el   = b_q[b_idx +: W];
    prod   = $signed({{W{a_el[W-1]}}, a_el}) * $signed({{W{b_el[W-1]}}, b_el});
    sum    = acc_q + {{(AW-2*W){prod[2*W-1]}}, prod};
    scaled = sum >>> BIN_POS;
    hi     = scaled[AW-1:W-1];
    sat    = !((&hi) || !(|hi));
    elem   = scaled[W-1:0];
    if (sat) elem = scaled[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

  // Operand capture, index walk and progressive result write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      c_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      result   <= '0;
      overflow <= 1'b0;
      singular <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          a_q      <= mat_a;
          b_q      <= mat_b;
          singular <= a_singular;
          r_q      <= '0;
          c_q      <= '0;
          k_q      <= '0;
          acc_q    <= '0;
          result   <= '0;
          overflow <= 1'b0;
        end
        MAC: begin
          if (k_q != LAST) begin
            acc_q <= sum;
            k_q   <= k_q + 1'b1;
          end else begin
            result[c_idx +: W] <= elem;
            if (sat) overflow <= 1'b1;
            acc_q <= '0;
            k_q   <= '0;
            if (c_q == LAST) begin
              c_q <= '0;
              r_q <= (r_q == LAST) ? '0 : r_q + 1'b1;
            end else begin
              c_q <= c_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_seq.sv
// Bench for matmul_seq: a 3x3 Q16.16 instance and a 2x2 Q8.8 instance,
// directed and random operands checked against an integer reference model.
module tb_matmul_seq;

  localparam int N  = 3, W  = 32, BP  = 16;
  localparam int NS = 2, WS = 16, BPS = 8;

  typedef longint mat_t [9];

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, ready, complete, a_singular, overflow, singular;
  logic [N*N*W-1:0]    mat_a, mat_b, result;
  logic                rst_s, ready_s, complete_s, a_singular_s, overflow_s, singular_s;
  logic [NS*NS*WS-1:0] mat_a_s, mat_b_s, result_s;

  int total = 0;
  int bad   = 0;

  matmul_seq #(.DATA_WIDTH(W), .BIN_POS(BP), .MATRIX_SIZE(N)) dut (
    .clk(clk), .rst(rst), .ready(ready), .complete(complete),
    .mat_a(mat_a), .mat_b(mat_b), .a_singular(a_singular),
    .result(result), .overflow(overflow), .singular(singular)
  );

  matmul_seq #(.DATA_WIDTH(WS), .BIN_POS(BPS), .MATRIX_SIZE(NS)) dut_s (
    .clk(clk), .rst(rst_s), .ready(ready_s), .complete(complete_s),
    .mat_a(mat_a_s), .mat_b(mat_b_s), .a_singular(a_singular_s),
    .result(result_s), .overflow(overflow_s), .singular(singular_s)
  );

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint rnd(input longint lim);
    return longint'($urandom_range(0, 32'(2 * lim))) - lim;
  endfunction

  // Reference: exact integer dot products, floor division by 2^bp, clamp.
  function automatic void model(input int n, input int w, input int bp,
                                input mat_t a, input mat_t b,
                                output mat_t c, output bit ovf);
    longint s, mx, mn;
    mx  = (longint'(1) <<< (w - 1)) - 1;
    mn  = -mx - 1;
    ovf = 1'b0;
    for (int i = 0; i < 9; i++) c[i] = 0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) s += a[i*n+k] * b[k*n+j];
        s = s >>> bp;
        if (s > mx) begin s = mx; ovf = 1'b1; end
        if (s < mn) begin s = mn; ovf = 1'b1; end
        c[i*n+j] = s;
      end
  endfunction

  function automatic logic [287:0] pack(input mat_t m, input int n, input int w);
    logic [287:0] v;
    longint       e;
    v = '0;
    for (int i = 0; i < n * n; i++) begin
      e = m[i];
      for (int bb = 0; bb < w; bb++) v[i*w+bb] = e[bb];
    end
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic run_big(input string tag, input mat_t a, input mat_t b, input bit sing);
    mat_t         c;
    bit           ovf;
    int           edges;
    logic [287:0] exp_res, va, vb;
    model(N, W, BP, a, b, c, ovf);
    if (sing) begin
      for (int i = 0; i < 9; i++) c[i] = 0;
      ovf = 1'b0;
    end
    exp_res = pack(c, N, W);
    va = pack(a, N, W);
    vb = pack(b, N, W);
    rst = 1'b1;
    mat_a = va[N*N*W-1:0];
    mat_b = vb[N*N*W-1:0];
    a_singular = sing;
    tick();
    rst = 1'b0;
    tick();                                   // edge 1
    chk({tag, "_ready_low"}, ready, 1'b0);
    tick();                                   // edge 2: operands captured
    edges = 2;
    mat_a = {9{$urandom()}};
    mat_b = {9{$urandom()}};
    a_singular = ~sing;
    while (!complete && edges < 200) begin
      tick();
      edges++;
    end
    chk({tag, "_latency"}, edges, sing ? 2 : N*N*N + 2);
    chk({tag, "_result"}, result, exp_res[N*N*W-1:0]);
    chk({tag, "_overflow"}, overflow, ovf);
    chk({tag, "_singular"}, singular, sing);
    repeat (4) tick();
    chk({tag, "_hold"}, {complete, result}, {1'b1, exp_res[N*N*W-1:0]});
  endtask

  task automatic run_small(input string tag, input mat_t a, input mat_t b);
    mat_t         c;
    bit           ovf;
    int           edges;
    logic [287:0] exp_res, va, vb;
    model(NS, WS, BPS, a, b, c, ovf);
    exp_res = pack(c, NS, WS);
    va = pack(a, NS, WS);
    vb = pack(b, NS, WS);
    rst_s = 1'b1;
    mat_a_s = va[NS*NS*WS-1:0];
    mat_b_s = vb[NS*NS*WS-1:0];
    a_singular_s = 1'b0;
    tick();
    rst_s = 1'b0;
    tick();
    tick();
    edges = 2;
    mat_a_s = {2{$urandom()}};
    mat_b_s = {2{$urandom()}};
    while (!complete_s && edges < 200) begin
      tick();
      edges++;
    end
    chk({tag, "_latency"}, edges, NS*NS*NS + 2);
    chk({tag, "_result"}, result_s, exp_res[NS*NS*WS-1:0]);
    chk({tag, "_overflow"}, overflow_s, ovf);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    mat_t a, b;
    rst = 1'b1; rst_s = 1'b1;
    a_singular = 1'b0; a_singular_s = 1'b0;
    mat_a = '0; mat_b = '0; mat_a_s = '0; mat_b_s = '0;
    repeat (2) tick();

    // Reset state of both instances.
    chk("rst_ready", ready, 1'b1);
    chk("rst_complete", complete, 1'b0);
    chk("rst_result", result, '0);
    chk("rst_flags", {overflow, singular}, 2'b00);
    chk("rst_s_state", {ready_s, complete_s, overflow_s, singular_s}, 4'b1000);
    chk("rst_s_result", result_s, '0);

    // Identity A, random B in +-10.0: result equals B.
    for (int i = 0; i < 9; i++) begin
      a[i] = (i % 4 == 0) ? 64'sh10000 : 0;
      b[i] = rnd(655360);
    end
    run_big("ident", a, b, 1'b0);
    chk("ident_eq_b", result, pack(b, N, W));

    // Diagonal 2.0 times all-1.5: every element 3.0.
    for (int i = 0; i < 9; i++) begin
      a[i] = (i % 4 == 0) ? 64'sh20000 : 0;
      b[i] = 64'sh18000;
    end
    run_big("diag", a, b, 1'b0);
    chk("diag_c00", result[0 +: 32], 32'h00030000);
    chk("diag_c22", result[8*32 +: 32], 32'h00030000);

    // Mixed signs and floor truncation.
    for (int i = 0; i < 9; i++) begin
      a[i] = 0;
      b[i] = rnd(655360);
    end
    a[0] = -64'sh18000;
    a[3] = 1;
    a[6] = -1;
    b[0] = 64'sh10000;
    b[1] = 64'sh8000;
    run_big("mixed", a, b, 1'b0);
    chk("mixed_c00", result[0 +: 32], 32'hFFFE8000);
    chk("trunc_pos", result[4*32 +: 32], 32'h00000000);
    chk("trunc_neg", result[7*32 +: 32], 32'hFFFFFFFF);

    // Random wide-range operands (some saturate).
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 9; i++) begin
        a[i] = rnd(268435456);
        b[i] = rnd(268435456);
      end
      run_big("rand_wide", a, b, 1'b0);
    end

    // Singular abort, then a normal operation.
    run_big("sing", a, b, 1'b1);
    for (int i = 0; i < 9; i++) begin
      a[i] = rnd(655360);
      b[i] = rnd(655360);
    end
    run_big("after_sing", a, b, 1'b0);

    // Asynchronous reset during MAC edge 10.
    for (int i = 0; i < 9; i++) begin
      a[i] = rnd(655360);
      b[i] = rnd(655360);
    end
    begin
      logic [287:0] va, vb;
      va = pack(a, N, W);
      vb = pack(b, N, W);
      rst = 1'b1;
      mat_a = va[N*N*W-1:0];
      mat_b = vb[N*N*W-1:0];
      a_singular = 1'b0;
      tick();
      rst = 1'b0;
      repeat (12) tick();
      #2 rst = 1'b1;
      #1;
      chk("midrst_state", {ready, complete, overflow, singular}, 4'b1000);
      chk("midrst_result", result, '0);
    end
    for (int i = 0; i < 9; i++) begin
      a[i] = rnd(655360) | 64'sh100;
      b[i] = rnd(655360);
    end
    run_big("after_midrst", a, b, 1'b0);

    // Q8.8 saturation, both signs.
    for (int i = 0; i < 4; i++) begin
      a[i] = 64'sh6400;
      b[i] = 64'sh6400;
    end
    run_small("sat_pos", a, b);
    chk("sat_pos_c11", result_s[3*16 +: 16], 16'h7FFF);
    for (int i = 0; i < 4; i++) a[i] = -64'sh6400;
    run_small("sat_neg", a, b);
    chk("sat_neg_c00", result_s[0 +: 16], 16'h8000);
    chk("sat_neg_ovf", overflow_s, 1'b1);

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 4; i++) begin
        a[i] = rnd(4096);
        b[i] = rnd(4096);
      end
      run_small("rand_small", a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matmul_seq.md
Name: matmul_seq

Overview:
- Sequential fixed-point signed matrix multiplier, C = A x B, square MATRIX_SIZE matrices.
- Sits directly downstream of the matrix inverter in the navigation filter datapath. Its A operand is the inverter's inverse output, B is supplied by the filter control, e.g. H^T or a covariance product for gain computation.
- Uses one shared multiply-accumulate unit, one MAC per clock.
- Follows the block-level handshake used throughout the datapath: rst held high = idle/load, ready/complete outputs.

Parameters:
- DATA_WIDTH, 32, element width in bits, two's complement.
- BIN_POS, 16, number of fractional bits, 0 <= BIN_POS < DATA_WIDTH.
- MATRIX_SIZE, 3, matrix dimension N, N >= 1.

Ports:
- clk  input  1  clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset; also the start control (deassert = start).
- ready  output  1  block idle and able to accept a new operation.
- complete  output  1  result valid.
- mat_a  input  N*N*DATA_WIDTH  A operand; element (r,c) at bits [(r*N+c)*DATA_WIDTH +: DATA_WIDTH].
- mat_b  input  N*N*DATA_WIDTH  B operand, same packing.
- a_singular  input  1  upstream inverter flagged A invalid.
- result  output  N*N*DATA_WIDTH  C, same packing.
- overflow  output  1  at least one element of C saturated.
- singular  output  1  operation aborted because a_singular was set.

Behaviour:
- Reset is asynchronous, active-high. While rst=1: state=IDLE, ready=1, complete=0, overflow=0, singular=0, result=0, accumulator and all indices = 0. Effective immediately on rst rising, including mid-operation; no partial result survives.
- States: IDLE -> LOAD -> MAC -> DONE.
- IDLE: leaves on the first rising edge of clk with rst=0. Until then, mat_a, mat_b and a_singular are ignored.
- LOAD (1 edge): registers mat_a, mat_b and a_singular internally. Input ports may change freely afterwards. ready=0 from this edge.
  - If registered a_singular=1: go directly to DONE with singular=1, result=0, overflow=0.
  - Otherwise: indices r=c=k=0, acc=0, go to MAC.
- MAC (N^3 edges): each edge computes p = A[r][k]*B[k][c] as a full 2*DATA_WIDTH signed product, then sum = acc + p.
  - Accumulator width is 2*DATA_WIDTH + clog2(N) + 1; it never wraps.
  - If k<N-1: acc<=sum, k<=k+1.
  - If k=N-1: write the scaled sum to result element (r,c), set acc<=0, k<=0, and advance c. When c wraps, advance r.
  - After element (N-1,N-1) is written, go to DONE.
- Scaling: arithmetic right shift of sum by BIN_POS, i.e. truncation toward negative infinity; no rounding.
- Saturation: if the scaled value is outside the DATA_WIDTH signed range, clamp to 0x7F..F or 0x80..0 and set the sticky overflow flag.
- DONE: complete=1. result, overflow and singular are held stable until rst is asserted; the block stays in DONE indefinitely.
- Latency: with rst low before edge 1, complete rises after edge N^3+2 (29 for N=3) on the normal path, and after edge 2 on the singular path.
- Result elements are written progressively during MAC; consumers read result only while complete=1.
- N=1: a single MAC edge; latency is 3 edges.
- rst deasserted in the same cycle it is released by the downstream block: treated as a new start; no lost operation.
- Any input change during MAC or DONE has no effect.

Test Plan:
- N=3, W=32, BP=16, A=identity (diagonal 0x00010000), B random in ±10.0 -> result==B bit-exact, overflow=0, singular=0, complete first high after edge 29, ready low from edge 1.
- Diagonal A = 2.0 (0x00020000), B all 1.5 (0x00018000) -> every diagonal-row product element = 0x00030000.
- Mixed signs, N=3: A row 0 = [-1.5, 0, 0], B(0,0)=1.0 -> C(0,0)=0xFFFE8000. Truncation checks: 0x00000001*0x00008000 -> 0x00000000; 0xFFFFFFFF*0x00008000 -> 0xFFFFFFFF.
- Saturation, N=2, W=16, BP=8: all A and B elements 0x6400 (100.0) -> every element 0x7FFF, overflow=1. Same test with A negated (0x9C00) -> 0x8000, overflow=1.
- a_singular=1 at start -> complete after edge 2, singular=1, result=0, overflow=0. Then a_singular=0 with a new operation after an rst pulse -> normal result and singular=0.
- Reset mid-operation: assert rst asynchronously (between edges) at MAC edge 10 -> ready=1, complete=0, result=0 immediately. Release rst with new operands -> correct product at full latency, with no stale elements.
